// File: rtl/harvard_data_ram.sv
// harvard_data_ram: data-side memory model for mips_cpu_harvard benches.
//
// This is a byte-addressed RAM organised as 32-bit words, with byte enables. The base address and
// the depth can be set by parameter. A combinational debug port lets a bench read any word
// without driving the CPU bus. Optional wait states are enabled by defining the macro
// DRAM_WAIT_EN.
//
// Parameters:
//   ADDR_BASE    byte address of word 0 (4-byte aligned)
//   DEPTH_WORDS  number of 32-bit words in the window
//   INIT_FILE    image name; contents start all zero
//   WAIT_CYCLES  stall cycles per access (0..15); only used when DRAM_WAIT_EN is defined
//
// Ports:
//   clk, reset_n        clock and asynchronous active-low reset
//   data_address        CPU byte address
//   data_write          write strobe
//   data_read           read strobe
//   data_byteenable     write lane enables; bit n covers bits [8n+7:8n]
//   data_writedata      write data
//   data_readdata       read data (0 when there is no read or the address is out of window)
//   data_waitrequest    1 = access still pending; the CPU holds the request
//   dbg_address         backdoor byte address
//   dbg_readdata        word at dbg_address (0 when out of window)
//   err_flags           sticky: [0] out-of-window, [1] misaligned, [2] read and write together
//   write_count         number of committed writes since reset
module harvard_data_ram #(
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter string       INIT_FILE   = "",
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] data_address,
    input  logic        data_write,
    input  logic        data_read,
    input  logic [3:0]  data_byteenable,
    input  logic [31:0] data_writedata,
    output logic [31:0] data_readdata,
    output logic        data_waitrequest,
    input  logic [31:0] dbg_address,
    output logic [31:0] dbg_readdata,
    output logic [2:0]  err_flags,
    output logic [31:0] write_count
);

    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    logic [31:0] mem [DEPTH_WORDS];

    // Memory is not reset, so its contents survive reset_n.
    initial begin
        for (int unsigned i = 0; i < DEPTH_WORDS; i++) mem[i] = '0;
    end

    // CPU-side decode
    logic [29:0]      data_word;
    logic             data_in_win;
    logic [IDX_W-1:0] data_idx;
    logic             strobe;
    logic             wr_commit;

    assign data_word   = data_address[31:2] - ADDR_BASE[31:2];
    assign data_in_win = (data_address >= ADDR_BASE) && ({2'b00, data_word} < DEPTH_WORDS);
    assign data_idx    = data_word[IDX_W-1:0];
    assign strobe      = data_read | data_write;

    assign data_readdata = (data_read && data_in_win) ? mem[data_idx] : '0;

    // Debug-side decode; the low address bits play no part in a word lookup.
    logic [29:0]      dbg_word;
    logic             dbg_in_win;
    logic [IDX_W-1:0] dbg_idx;
    logic [1:0]       unused_dbg_lsb;

    assign dbg_word       = dbg_address[31:2] - ADDR_BASE[31:2];
    assign dbg_in_win     = (dbg_address >= ADDR_BASE) && ({2'b00, dbg_word} < DEPTH_WORDS);
    assign dbg_idx        = dbg_word[IDX_W-1:0];
    assign dbg_readdata   = dbg_in_win ? mem[dbg_idx] : '0;
    assign unused_dbg_lsb = dbg_address[1:0];

`ifdef DRAM_WAIT_EN
    typedef enum logic {StIdle, StWait} state_t;

    state_t     state_q;
    logic [3:0] cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (strobe && data_in_win && (WAIT_CYCLES != 0)) begin
                        state_q <= StWait;
                        cnt_q   <= 4'(WAIT_CYCLES - 1);
                    end
                end
                StWait: begin
                    // A dropped strobe aborts the access, and so does the final cycle.
                    if (!strobe || (cnt_q == 4'd0)) state_q <= StIdle;
                    else                            cnt_q   <= cnt_q - 4'd1;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        data_waitrequest = 1'b0;
        if (reset_n) begin
            case (state_q)
                StIdle:  data_waitrequest = strobe && data_in_win && (WAIT_CYCLES != 0);
                StWait:  data_waitrequest = strobe && (cnt_q != 4'd0);
                default: data_waitrequest = 1'b0;
            endcase
        end
    end
`else
    logic unused_wait_cfg;

    assign data_waitrequest = 1'b0;
    assign unused_wait_cfg  = (WAIT_CYCLES != 0);
`endif

    // A combined read and write is treated as a read only.
    assign wr_commit = reset_n && data_write && !data_read && data_in_win && !data_waitrequest;

    always_ff @(posedge clk) begin
        if (wr_commit) begin
            for (int n = 0; n < 4; n++) begin
                if (data_byteenable[n]) mem[data_idx][8*n +: 8] <= data_writedata[8*n +: 8];
            end
        end
    end

    logic [2:0]  err_q;
    logic [31:0] wcount_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q    <= 3'b000;
            wcount_q <= 32'd0;
        end else begin
            if (strobe) begin
                err_q <= err_q | {data_read & data_write, data_address[1:0] != 2'b00, !data_in_win};
            end
            if (wr_commit) wcount_q <= wcount_q + 32'd1;
        end
    end

    assign err_flags   = err_q;
    assign write_count = wcount_q;

endmodule

// File: tb/tb_harvard_data_ram.sv
module tb_harvard_data_ram;

    logic        clk;
    logic        reset_n;
    logic [31:0] addr;
    logic        wr;
    logic        rd;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] dbg_addr;

    logic [31:0] rdata_a, dbg_a, wc_a;
    logic        wait_a;
    logic [2:0]  err_a;
    logic [31:0] rdata_b, dbg_b, wc_b;
    logic        wait_b;
    logic [2:0]  err_b;

    int errors = 0;
    int checks = 0;

    // Instance A: window 0x0000..0x0FFF, default wait configuration.
    harvard_data_ram #(
        .ADDR_BASE   (32'h0000_0000),
        .DEPTH_WORDS (1024),
        .INIT_FILE   (""),
        .WAIT_CYCLES (2)
    ) u_dut_a (
        .clk              (clk),
        .reset_n          (reset_n),
        .data_address     (addr),
        .data_write       (wr),
        .data_read        (rd),
        .data_byteenable  (be),
        .data_writedata   (wd),
        .data_readdata    (rdata_a),
        .data_waitrequest (wait_a),
        .dbg_address      (dbg_addr),
        .dbg_readdata     (dbg_a),
        .err_flags        (err_a),
        .write_count      (wc_a)
    );

    // Instance B: window 0x1000..0x103F, no wait states.
    harvard_data_ram #(
        .ADDR_BASE   (32'h0000_1000),
        .DEPTH_WORDS (16),
        .INIT_FILE   (""),
        .WAIT_CYCLES (0)
    ) u_dut_b (
        .clk              (clk),
        .reset_n          (reset_n),
        .data_address     (addr),
        .data_write       (wr),
        .data_read        (rd),
        .data_byteenable  (be),
        .data_writedata   (wd),
        .data_readdata    (rdata_b),
        .data_waitrequest (wait_b),
        .dbg_address      (dbg_addr),
        .dbg_readdata     (dbg_b),
        .err_flags        (err_b),
        .write_count      (wc_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called just after an edge; holds the request until instance A stops stalling.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        logic done;
        done = 1'b0;
        addr = a; wd = d; be = b; wr = 1'b1; rd = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            #2;
            done = !wait_a;
            @(posedge clk); #1;
        end
        wr = 1'b0;
        if (!done) check("write_timeout", 32'd1, 32'd0);
    endtask

    task automatic bus_read(input logic [31:0] a, input logic [31:0] exp, input string tag);
        logic done;
        done = 1'b0;
        addr = a; rd = 1'b1; wr = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            #2;
            if (!wait_a) begin
                done = 1'b1;
                check(tag, rdata_a, exp);
            end
            @(posedge clk); #1;
        end
        rd = 1'b0;
        if (!done) check("read_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        reset_n = 1'b0; addr = '0; wr = 1'b0; rd = 1'b0; be = '0; wd = '0; dbg_addr = '0;
        #8;
        check("reset_err", {29'd0, err_a}, 32'd0);
        check("reset_wcount", wc_a, 32'd0);
        check("reset_wait", {31'd0, wait_a}, 32'd0);
        check("reset_dbg0", dbg_a, 32'd0);
        #4 reset_n = 1'b1;
        @(posedge clk); #1;

        // Word 0 loaded through the bus, read back on both ports
        bus_write(32'h0, 32'h7856_3412, 4'b1111);
        bus_read(32'h0, 32'h7856_3412, "read_word0");
        dbg_addr = 32'h0; #1;
        check("dbg_word0", dbg_a, 32'h7856_3412);
        check("rdata_no_strobe", rdata_a, 32'd0);

        // Byte-lane merges over an all-zero word
        bus_write(32'h100, 32'hAABB_CCDD, 4'b0101);
        dbg_addr = 32'h100; #1;
        check("be_0101", dbg_a, 32'h00BB_00DD);
        check("wcount_2", wc_a, 32'd2);
        bus_write(32'h100, 32'h1122_3344, 4'b1010);
        check("be_1010", dbg_a, 32'h11BB_33DD);
        bus_write(32'h100, 32'hFFFF_FFFF, 4'b0000);
        check("be_0000", dbg_a, 32'h11BB_33DD);
        check("wcount_be0", wc_a, 32'd4);
        check("err_clean", {29'd0, err_a}, 32'd0);
        dbg_addr = 32'h1000; #1;
        check("dbg_out_of_window", dbg_a, 32'd0);

        // Reset clears the counters but not the memory
        reset_n = 1'b0; #2;
        check("rst_wcount", wc_a, 32'd0);
        check("rst_err_b", {29'd0, err_b}, 32'd0);
        reset_n = 1'b1;
        dbg_addr = 32'h100; #1;
        check("mem_persists", dbg_a, 32'h11BB_33DD);
        @(posedge clk); #1;

        // Below B's base address: dropped by B, kept by A
        bus_write(32'h0FFC, 32'hDEAD_BEEF, 4'b1111);
        check("b_err_oow", {29'd0, err_b}, 32'd1);
        check("b_wcount_drop", wc_b, 32'd0);
        dbg_addr = 32'h0FFC; #1;
        check("b_dbg_drop", dbg_b, 32'd0);
        check("a_dbg_fffc", dbg_a, 32'hDEAD_BEEF);
        addr = 32'h0FFC; rd = 1'b1; #1;
        check("b_read_oow", rdata_b, 32'd0);
        rd = 1'b0;
        @(posedge clk); #1;
        bus_write(32'h1004, 32'h0102_0304, 4'b1111);
        dbg_addr = 32'h1004; #1;
        check("b_write_in_window", dbg_b, 32'h0102_0304);
        check("b_wcount", wc_b, 32'd1);
        check("a_wcount_oow", wc_a, 32'd1);

        // Combined read and write is performed as a read only
        bus_write(32'h104, 32'hCAFE_F00D, 4'b1111);
        addr = 32'h104; rd = 1'b1; wr = 1'b1; wd = 32'h1234_5678; be = 4'b1111; #1;
        check("rw_readdata", rdata_a, 32'hCAFE_F00D);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (!wait_a) break;
        end
        rd = 1'b0; wr = 1'b0;
        dbg_addr = 32'h104; #1;
        check("rw_no_write", dbg_a, 32'hCAFE_F00D);
        check("rw_wcount", wc_a, 32'd2);
        check("rw_err", {29'd0, err_a}, 32'd5);

        // A misaligned read returns the containing word
        bus_read(32'h102, 32'h11BB_33DD, "misaligned_read");
        check("misaligned_err", {29'd0, err_a}, 32'd7);

`ifdef DRAM_WAIT_EN
        // A read stalls for two cycles and completes on the third
        addr = 32'h100; rd = 1'b1; #1;
        check("wait_c1", {31'd0, wait_a}, 32'd1);
        @(posedge clk); #1;
        check("wait_c2", {31'd0, wait_a}, 32'd1);
        @(posedge clk); #1;
        check("wait_c3", {31'd0, wait_a}, 32'd0);
        check("wait_rdata", rdata_a, 32'h11BB_33DD);
        @(posedge clk); #1;
        rd = 1'b0;
        check("wait_read_wcount", wc_a, 32'd2);

        // Reset during the stall throws the pending write away
        addr = 32'h200; wr = 1'b1; wd = 32'h5555_5555; be = 4'b1111;
        @(posedge clk); #1;
        reset_n = 1'b0; #1;
        check("rst_mid_wait", {31'd0, wait_a}, 32'd0);
        check("rst_mid_wcount", wc_a, 32'd0);
        wr = 1'b0;
        #1 reset_n = 1'b1;
        @(posedge clk); #1;
        dbg_addr = 32'h200; #1;
        check("rst_mid_word", dbg_a, 32'd0);
`else
        addr = 32'h100; rd = 1'b1; #1;
        check("nowait_read", {31'd0, wait_a}, 32'd0);
        check("nowait_rdata", rdata_a, 32'h11BB_33DD);
        rd = 1'b0;
        @(posedge clk); #1;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
